// File: rtl/memory_seq_ctrl.sv
// Memory sequence controller: records user entries into an external RAM,
// plays them back with a per-item hold time, then checks user replay.
module memory_seq_ctrl #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_play,
   input  logic       start_record,
   input  logic [3:0] level,
   input  logic       entry_valid,
   input  logic [3:0] entry,
   output logic [3:0] ram_addr,
   output logic       ram_we,
   output logic [3:0] ram_data,
   input  logic [3:0] ram_q,
   output logic       show_valid,
   output logic [3:0] show_data,
   output logic       busy,
   output logic       done,
   output logic       hit,
   output logic       miss
);

   typedef enum logic [2:0] {
      IDLE,
      SHOW_ADDR,
      SHOW_HOLD,
      WAIT_ENTRY,
      CHECK,
      REC_WAIT,
      REC_WRITE,
      FINISH
   } state_t;

   localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);

   state_t     state, state_nx;
   logic [3:0] idx, idx_nx;
   logic [3:0] lim, lim_nx;
   logic [3:0] ent, ent_nx;
   logic [3:0] wdata, wdata_nx;
   logic [7:0] hold, hold_nx;
   logic       hit_flag, hit_nx;
   logic       miss_flag, miss_nx;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         lim       <= '0;
         ent       <= '0;
         wdata     <= '0;
         hold      <= '0;
         hit_flag  <= 1'b0;
         miss_flag <= 1'b0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         lim       <= lim_nx;
         ent       <= ent_nx;
         wdata     <= wdata_nx;
         hold      <= hold_nx;
         hit_flag  <= hit_nx;
         miss_flag <= miss_nx;
      end
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      lim_nx   = lim;
      ent_nx   = ent;
      wdata_nx = wdata;
      hold_nx  = hold;
      hit_nx   = hit_flag;
      miss_nx  = miss_flag;
      unique case (state)
         IDLE: begin
            if (start_play || start_record) begin
               lim_nx   = level;
               idx_nx   = '0;
               hit_nx   = 1'b0;
               miss_nx  = 1'b0;
               state_nx = start_play ? SHOW_ADDR : REC_WAIT;
            end
         end
         SHOW_ADDR: begin
            hold_nx  = HOLD_INIT;
            state_nx = SHOW_HOLD;
         end
         SHOW_HOLD: begin
            if (hold <= 8'd1) begin
               if (idx == lim) begin
                  idx_nx   = '0;
                  state_nx = WAIT_ENTRY;
               end else begin
                  idx_nx   = idx + 4'd1;
                  state_nx = SHOW_ADDR;
               end
            end else begin
               hold_nx = hold - 8'd1;
            end
         end
         WAIT_ENTRY: begin
            if (entry_valid) begin
               ent_nx   = entry;
               state_nx = CHECK;
            end
         end
         CHECK: begin
            if (ent != ram_q) begin
               miss_nx  = 1'b1;
               state_nx = FINISH;
            end else if (idx == lim) begin
               hit_nx   = 1'b1;
               state_nx = FINISH;
            end else begin
               idx_nx   = idx + 4'd1;
               state_nx = WAIT_ENTRY;
            end
         end
         REC_WAIT: begin
            if (entry_valid) begin
               wdata_nx = entry;
               state_nx = REC_WRITE;
            end
         end
         REC_WRITE: begin
            if (idx == lim) begin
               state_nx = FINISH;
            end else begin
               idx_nx   = idx + 4'd1;
               state_nx = REC_WAIT;
            end
         end
         FINISH: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs decode straight from state so reset clears them at once.
   assign ram_addr   = idx;
   assign ram_we     = (state == REC_WRITE);
   assign ram_data   = wdata;
   assign show_valid = (state == SHOW_HOLD);
   assign show_data  = show_valid ? ram_q : 4'd0;
   assign busy       = (state != IDLE);
   assign done       = (state == FINISH);
   assign hit        = hit_flag;
   assign miss       = miss_flag;

endmodule
